// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF/ID stage.
//   NOP_INSTR  : canonical RISC-V NOP (addi x0,x0,0) loaded into IF/ID on reset/flush
//   PC_STEP    : sequential fetch increment
//   OPC_*      : opcodes whose instructions read rs2
//   state_e    : IF/ID controller states
//   uses_rs2() : true when the opcode actually reads the rs2 field
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [63:0] PC_STEP    = 64'd4;
  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    FETCH_INIT = 1'b0,
    RUN        = 1'b1
  } state_e;

  // Only R, S and B formats carry a register in bits [24:20]; elsewhere it is immediate.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OPC_RTYPE:  used = 1'b1;
      OPC_STORE:  used = 1'b1;
      OPC_BRANCH: used = 1'b1;
      default:    used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   valid_i   : IF/ID holds a real instruction
//   opcode_i  : IF/ID opcode field [6:0]
//   rs1_i     : IF/ID rs1 field
//   rs2_i     : IF/ID rs2 field (ignored when the opcode has no rs2)
//   memread_i : instruction in ID/EX is a load
//   rd_i      : destination of the instruction in ID/EX
//   hazard_o  : the IF/ID instruction needs the load result next cycle
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       valid_i,
  input  logic [6:0] opcode_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       memread_i,
  input  logic [4:0] rd_i,
  output logic       hazard_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Loads to x0 never produce a value, so they can never create a dependency.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    hazard_o  = 1'b0;
    if (valid_i && memread_i && (rd_i != 5'd0)) begin
      rs1_hit_s = (rd_i == rs1_i);
      rs2_hit_s = uses_rs2(opcode_i) && (rd_i == rs2_i);
      hazard_o  = rs1_hit_s || rs2_hit_s;
    end else begin
      hazard_o  = 1'b0;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register, load-use stall and branch flush.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   instr_in            : instruction memory data for pc_out
//   branch_taken_in/branch_target_in : redirect resolved in EX
//   idex_MemRead_in/idex_rd_in       : load currently in ID/EX
//   pc_out              : fetch address
//   ifid_pc_out/ifid_instr_out/ifid_valid_out : IF/ID contents
//   rs1_out/rs2_out/rd_out           : register fields of ifid_instr_out
//   stall_out           : hold PC and IF/ID this cycle
//   bubble_out          : ID/EX captures all-zero control this cycle
//   stall_cnt_out       : saturating stall-cycle count (only with IF_ID_STALL_CNT_EN)
// Optional feature macro: IF_ID_STALL_CNT_EN
module if_id_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        branch_taken_in,
  input  logic [63:0] branch_target_in,
  input  logic        idex_MemRead_in,
  input  logic [4:0]  idex_rd_in,
  output logic [63:0] pc_out,
  output logic [63:0] ifid_pc_out,
  output logic [31:0] ifid_instr_out,
  output logic        ifid_valid_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        stall_out,
  output logic        bubble_out
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_out
`endif
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        hazard_s;
  logic        stall_s;
  logic        bubble_s;

  hazard_detect u_hazard_detect (
    .valid_i   (ifid_valid_q),
    .opcode_i  (ifid_instr_q[6:0]),
    .rs1_i     (ifid_instr_q[19:15]),
    .rs2_i     (ifid_instr_q[24:20]),
    .memread_i (idex_MemRead_in),
    .rd_i      (idex_rd_in),
    .hazard_o  (hazard_s)
  );

  // Next-state logic: a taken branch outranks a hazard, which outranks sequential fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_s      = 1'b0;
    bubble_s     = 1'b0;
    case (state_q)
      FETCH_INIT: begin
        // First fetch of pc 0 is in flight; nothing to latch and redirects are ignored.
        state_d = RUN;
      end
      RUN: begin
        // The ID instruction never issues on a hazard, even when a branch flushes it.
        bubble_s = hazard_s;
        if (branch_taken_in) begin
          pc_d         = branch_target_in;
          ifid_pc_d    = 64'd0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (hazard_s) begin
          stall_s = 1'b1;
        end else begin
          pc_d         = pc_q + PC_STEP;
          ifid_pc_d    = pc_q;
          ifid_instr_d = instr_in;
          ifid_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = FETCH_INIT;
      end
    endcase
  end

  // Pipeline state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_INIT;
      pc_q         <= 64'd0;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

  assign pc_out         = pc_q;
  assign ifid_pc_out    = ifid_pc_q;
  assign ifid_instr_out = ifid_instr_q;
  assign ifid_valid_out = ifid_valid_q;
  assign rs1_out        = ifid_instr_q[19:15];
  assign rs2_out        = ifid_instr_q[24:20];
  assign rd_out         = ifid_instr_q[11:7];
  assign stall_out      = stall_s;
  assign bubble_out     = bubble_s;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        branch_taken_in;
  logic [63:0] branch_target_in;
  logic        idex_MemRead_in;
  logic [4:0]  idex_rd_in;
  logic [63:0] pc_out;
  logic [63:0] ifid_pc_out;
  logic [31:0] ifid_instr_out;
  logic        ifid_valid_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic        stall_out;
  logic        bubble_out;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_out;
`endif

  int n_cmp;
  int n_fail;

  if_id_stage dut (
    .clk              (clk),
    .rst              (rst),
    .instr_in         (instr_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .idex_MemRead_in  (idex_MemRead_in),
    .idex_rd_in       (idex_rd_in),
    .pc_out           (pc_out),
    .ifid_pc_out      (ifid_pc_out),
    .ifid_instr_out   (ifid_instr_out),
    .ifid_valid_out   (ifid_valid_out),
    .rs1_out          (rs1_out),
    .rs2_out          (rs2_out),
    .rd_out           (rd_out),
    .stall_out        (stall_out),
    .bubble_out       (bubble_out)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt_out    (stall_cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic [63:0] tgt;
    logic        mr;
    logic [4:0]  rd;
    logic        e_stall;
    logic        e_bubble;
    logic [63:0] e_pc;
    logic [63:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic br, input logic [63:0] tgt,
                              input logic mr, input logic [4:0] rd, input logic e_stall,
                              input logic e_bubble, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                              input logic [31:0] e_instr, input logic e_valid);
    vec_t v;
    v.instr = instr; v.br = br; v.tgt = tgt; v.mr = mr; v.rd = rd;
    v.e_stall = e_stall; v.e_bubble = e_bubble; v.e_pc = e_pc; v.e_ifpc = e_ifpc;
    v.e_instr = e_instr; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic check_regs(input string tag, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                            input logic [31:0] e_instr, input logic e_valid);
    logic [31:0] ei;
    ei = e_instr;
    chk({tag, ".pc"}, pc_out, e_pc);
    chk({tag, ".ifid_pc"}, ifid_pc_out, e_ifpc);
    chk({tag, ".ifid_instr"}, {32'd0, ifid_instr_out}, {32'd0, ei});
    chk({tag, ".ifid_valid"}, {63'd0, ifid_valid_out}, {63'd0, e_valid});
    chk({tag, ".rs1"}, {59'd0, rs1_out}, {59'd0, ei[19:15]});
    chk({tag, ".rs2"}, {59'd0, rs2_out}, {59'd0, ei[24:20]});
    chk({tag, ".rd"}, {59'd0, rd_out}, {59'd0, ei[11:7]});
  endtask

  initial begin
    int exp_cnt;
    n_cmp = 0;
    n_fail = 0;
    exp_cnt = 0;

    // ifid contents before each row noted in comments
    vecs[0]  = mk(32'h0050_8193, 1'b0, 64'h0,   1'b1, 5'd2, 1'b1, 1'b1, 64'h4,   64'h0,   32'h0020_81B3, 1'b1); // add x3,x1,x2: rs2 hit
    vecs[1]  = mk(32'h0050_8193, 1'b0, 64'h0,   1'b1, 5'd1, 1'b1, 1'b1, 64'h4,   64'h0,   32'h0020_81B3, 1'b1); // rs1 hit
    vecs[2]  = mk(32'h0050_8193, 1'b0, 64'h0,   1'b1, 5'd3, 1'b0, 1'b0, 64'h8,   64'h4,   32'h0050_8193, 1'b1); // rd field is not a source
    vecs[3]  = mk(32'h0000_0033, 1'b0, 64'h0,   1'b1, 5'd5, 1'b0, 1'b0, 64'hC,   64'h8,   32'h0000_0033, 1'b1); // addi: imm bits not rs2
    vecs[4]  = mk(32'h0020_A023, 1'b0, 64'h0,   1'b1, 5'd0, 1'b0, 1'b0, 64'h10,  64'hC,   32'h0020_A023, 1'b1); // x0 load vs rs1=0
    vecs[5]  = mk(32'h0020_A023, 1'b0, 64'h0,   1'b0, 5'd0, 1'b0, 1'b0, 64'h14,  64'h10,  32'h0020_A023, 1'b1);
    vecs[6]  = mk(32'h0040_8063, 1'b0, 64'h0,   1'b1, 5'd2, 1'b1, 1'b1, 64'h14,  64'h10,  32'h0020_A023, 1'b1); // store rs2 hit
    vecs[7]  = mk(32'h0040_8063, 1'b0, 64'h0,   1'b0, 5'd2, 1'b0, 1'b0, 64'h18,  64'h14,  32'h0040_8063, 1'b1); // not a load
    vecs[8]  = mk(32'h0020_81B3, 1'b1, 64'h100, 1'b1, 5'd4, 1'b0, 1'b1, 64'h100, 64'h0,   32'h0000_0013, 1'b0); // branch rs2 hit + taken
    vecs[9]  = mk(32'h0020_81B3, 1'b0, 64'h0,   1'b1, 5'd0, 1'b0, 1'b0, 64'h104, 64'h100, 32'h0020_81B3, 1'b1); // invalid IF/ID
    vecs[10] = mk(32'h0020_A183, 1'b1, 64'h200, 1'b0, 5'd0, 1'b0, 1'b0, 64'h200, 64'h0,   32'h0000_0013, 1'b0); // plain branch
    vecs[11] = mk(32'h0020_A183, 1'b0, 64'h0,   1'b0, 5'd0, 1'b0, 1'b0, 64'h204, 64'h200, 32'h0020_A183, 1'b1);
    vecs[12] = mk(32'h0020_A183, 1'b0, 64'h0,   1'b1, 5'd2, 1'b0, 1'b0, 64'h208, 64'h204, 32'h0020_A183, 1'b1); // lw: rs2 field ignored
    vecs[13] = mk(32'h0020_A183, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd0, 1'b0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0000_0013, 1'b0);
    vecs[14] = mk(32'h0020_A183, 1'b0, 64'h0,   1'b0, 5'd0, 1'b0, 1'b0, 64'h0,
                  64'hFFFF_FFFF_FFFF_FFFC, 32'h0020_A183, 1'b1); // pc wraps

    rst = 1'b1;
    instr_in = 32'h0020_81B3;
    branch_taken_in = 1'b0;
    branch_target_in = 64'h0;
    idex_MemRead_in = 1'b1;
    idex_rd_in = 5'd0;

    // Reset held for two edges.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_regs("reset", 64'h0, 64'h0, 32'h0000_0013, 1'b0);
    chk("reset.stall", {63'd0, stall_out}, 64'd0);
    chk("reset.bubble", {63'd0, bubble_out}, 64'd0);
`ifdef IF_ID_STALL_CNT_EN
    chk("reset.cnt", {32'd0, stall_cnt_out}, 64'd0);
`endif

    // FETCH_INIT edge: branch must be ignored and IF/ID not loaded.
    @(negedge clk);
    rst = 1'b0;
    branch_taken_in = 1'b1;
    branch_target_in = 64'h200;
    @(posedge clk);
    #1;
    check_regs("init", 64'h0, 64'h0, 32'h0000_0013, 1'b0);
    chk("init.stall", {63'd0, stall_out}, 64'd0);

    // First RUN edge.
    @(negedge clk);
    branch_taken_in = 1'b0;
    idex_MemRead_in = 1'b0;
    @(posedge clk);
    #1;
    check_regs("run1", 64'h4, 64'h0, 32'h0020_81B3, 1'b1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      instr_in = vecs[i].instr;
      branch_taken_in = vecs[i].br;
      branch_target_in = vecs[i].tgt;
      idex_MemRead_in = vecs[i].mr;
      idex_rd_in = vecs[i].rd;
      #1;
      chk($sformatf("v%0d.stall", i), {63'd0, stall_out}, {63'd0, vecs[i].e_stall});
      chk($sformatf("v%0d.bubble", i), {63'd0, bubble_out}, {63'd0, vecs[i].e_bubble});
      if (vecs[i].e_stall) exp_cnt++;
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_instr, vecs[i].e_valid);
    end
`ifdef IF_ID_STALL_CNT_EN
    chk("cnt", {32'd0, stall_cnt_out}, {32'd0, exp_cnt[31:0]});
`endif

    // Reset overrides a coincident hazard and branch.
    @(negedge clk);
    rst = 1'b1;
    idex_MemRead_in = 1'b1;
    idex_rd_in = 5'd1;
    branch_taken_in = 1'b1;
    branch_target_in = 64'h300;
    @(posedge clk);
    #1;
    check_regs("midrst", 64'h0, 64'h0, 32'h0000_0013, 1'b0);
    chk("midrst.stall", {63'd0, stall_out}, 64'd0);
    chk("midrst.bubble", {63'd0, bubble_out}, 64'd0);
`ifdef IF_ID_STALL_CNT_EN
    chk("midrst.cnt", {32'd0, stall_cnt_out}, 64'd0);
`endif

    @(negedge clk);
    rst = 1'b0;
    branch_taken_in = 1'b0;
    idex_MemRead_in = 1'b0;
    instr_in = 32'h0050_8193;
    @(posedge clk);
    #1;
    check_regs("rel.init", 64'h0, 64'h0, 32'h0000_0013, 1'b0);
    @(posedge clk);
    #1;
    check_regs("rel.run", 64'h4, 64'h0, 32'h0050_8193, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
